hazard_ctrl_unit: RTL

Pipeline hazard controller that drives the `stall` and `flush` inputs of the IF/ID and ID/EXE pipeline registers, and the PC hold enable. It sits beside the decode and execute stages. It detects load-use hazards, taken branches resolved in EXE, and multi-cycle EXE operations (mul/div), then sequences the required bubbles and flushes. It also keeps saturating statistics counters for stall and flush activity.

---
 rtl/hazard_ctrl_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Pipeline hazard controller for the IF/ID and ID/EXE registers and the PC.
// It detects three hazards and inserts the bubbles and flushes they need:
//   - load-use: the instruction in ID reads the register that a load in EXE writes,
//   - a taken branch or jump resolved in EXE,
//   - a multi-cycle EXE operation (mul/div).
// It also keeps saturating counters of stall and flush activity.
//
// Ports:
//   clk, reset_n                   clock; asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs1/2   source registers of the ID instruction, and whether it reads them
//   ex_valid, ex_rd, ex_mem_read   EXE instruction: real (not a bubble), destination register, is a load
//   ex_branch_taken                EXE resolved a taken branch this cycle
//   ex_mc_start, ex_mc_done        first EXE cycle of a multi-cycle op / its result is valid
//   clear_counters                 synchronous clear of the statistics counters
//   stall_pc, stall_if_id, stall_id_exe, flush_if_id, flush_id_exe
//                                  Mealy control outputs, forced to 0 while in reset
//   hz_state                       RUN=0, LOAD_BUBBLE=1, MC_WAIT=2
//   mc_timeout                     sticky; set when a multi-cycle op never signals done
//   stall_cycles, flush_events     saturating statistics counters
//
// state       | meaning
// RUN         | normal flow; hazards are detected here
// LOAD_BUBBLE | the one bubble of a load-use is in EXE; no action this cycle
// MC_WAIT     | a multi-cycle op is in EXE; hold the front end until done or timeout
module hazard_ctrl_unit #(
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             clear_counters,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_exe,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic [1:0]       hz_state,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // The timer counts down from MC_TIMEOUT-1, so that value must fit in TMR_W bits.
  localparam int               TMR_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    MC_WAIT     = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             timeout_set;
  logic             load_use;
  logic             spc, sif, sie, fif, fie;
  logic             stall_any;

  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    timeout_set = 1'b0;
    spc         = 1'b0;
    sif         = 1'b0;
    sie         = 1'b0;
    fif         = 1'b0;
    fie         = 1'b0;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          fif = 1'b1;
          fie = 1'b1;
        end else if (ex_mc_start) begin
          // A single-cycle completion (done together with start) needs no hold.
          if (!ex_mc_done) begin
            spc       = 1'b1;
            sif       = 1'b1;
            sie       = 1'b1;
            state_nxt = MC_WAIT;
            tmr_nxt   = TMR_LOAD;
          end
        end else if (load_use) begin
          // Hold PC and IF/ID and flush ID/EXE, which puts one bubble into EXE.
          spc       = 1'b1;
          sif       = 1'b1;
          fie       = 1'b1;
          state_nxt = LOAD_BUBBLE;
        end
      end
      LOAD_BUBBLE: begin
        state_nxt = RUN;
      end
      MC_WAIT: begin
        if (ex_mc_done) begin
          state_nxt = RUN;
        end else if (tmr == '0) begin
          timeout_set = 1'b1;
          state_nxt   = RUN;
        end else begin
          spc     = 1'b1;
          sif     = 1'b1;
          sie     = 1'b1;
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // The state is already RUN during reset, but RUN reacts to inputs, so gate the outputs as well.
  assign stall_pc     = spc & reset_n;
  assign stall_if_id  = sif & reset_n;
  assign stall_id_exe = sie & reset_n;
  assign flush_if_id  = fif & reset_n;
  assign flush_id_exe = fie & reset_n;
  assign hz_state     = state;
  assign stall_any    = stall_pc | stall_if_id | stall_id_exe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      tmr        <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (timeout_set) begin
        mc_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (clear_counters) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_any && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush_if_id && (flush_events != CNT_MAX)) begin
        flush_events <= flush_events + 1'b1;
      end
    end
  end

endmodule
